// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: default widths, bus-source and
// ALU encodings, and the instruction opcodes decoded by the control unit.
package cpu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    BUS_MEM = 2'd0,
    BUS_DR  = 2'd1,
    BUS_PC  = 2'd2,
    BUS_AC  = 2'd3
  } bus_sel_e;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_sel_e;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_JMP   = 3'd4,
    OP_JEQ   = 3'd5
  } opcode_e;

endpackage

// File: rtl/accumulator_datapath_if.sv
// Control-unit <-> datapath bundle: load strobes, bus/ALU selects, the
// program-load port, and the opcode/zero flag returned to the control unit.
interface accumulator_datapath_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              ARLoad;
  logic              DRLoad;
  logic              PCLoad;
  logic              ACLoad;
  logic              IRLoad;
  logic              ALUSel;
  logic              PCInc;
  logic              memRW;
  logic [1:0]        BusSel;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [2:0]        IR;
  logic              Z;
  logic [DATA_W-1:0] ac_out;
  logic [ADDR_W-1:0] pc_out;

  // Control unit / program loader side.
  modport master (
    output ARLoad, DRLoad, PCLoad, ACLoad, IRLoad, ALUSel, PCInc, memRW,
    output BusSel, prog_we, prog_addr, prog_data,
    input  IR, Z, ac_out, pc_out
  );

  // Datapath side.
  modport slave (
    input  ARLoad, DRLoad, PCLoad, ACLoad, IRLoad, ALUSel, PCInc, memRW,
    input  BusSel, prog_we, prog_addr, prog_data,
    output IR, Z, ac_out, pc_out
  );

endinterface

// File: rtl/word_ram.sv
// Single-port word RAM with asynchronous read and one synchronous write port.
// The program-load port shares the write port and always wins over the CPU.
module word_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [DATA_W-1:0] prog_data_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;

  // Write-port arbitration: a program-load write suppresses the CPU write.
  always_comb begin
    wr_en_d   = prog_we_i | we_i;
    wr_addr_d = addr_i;
    wr_data_d = wdata_i;
    if (prog_we_i) begin
      wr_addr_d = prog_addr_i;
      wr_data_d = prog_data_i;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_d) begin
      mem_q[wr_addr_d] <= wr_data_d;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/accumulator_datapath.sv
// Register-transfer datapath of the accumulator CPU: AR, DR, PC, AC, IR, the
// shared 4-way bus, the add/sub ALU and the word RAM. Every register that is
// loaded in a cycle samples the same pre-edge bus value.
module accumulator_datapath
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic                   CLK,
  input logic                   RST,
  accumulator_datapath_if.slave dp
);

  logic [DATA_W-1:0] bus_w;
  logic [DATA_W-1:0] mem_rdata_w;
  logic              ram_we_w;

  logic [ADDR_W-1:0] ar_q, ar_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] dr_q, dr_d;
  logic [DATA_W-1:0] ac_q, ac_d;
  logic [2:0]        ir_q, ir_d;

  // Modulo add/subtract; carry and borrow are discarded by the result width.
  function automatic logic [DATA_W-1:0] alu_op(input logic sub,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    if (sub) r = a - b;
    else     r = a + b;
    return r;
  endfunction

  // Shared bus: PC is zero-extended, RAM is read combinationally at AR.
  always_comb begin
    bus_w = mem_rdata_w;
    case (bus_sel_e'(dp.BusSel))
      BUS_MEM: bus_w = mem_rdata_w;
      BUS_DR:  bus_w = dr_q;
      BUS_PC:  bus_w = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
      BUS_AC:  bus_w = ac_q;
      default: bus_w = mem_rdata_w;
    endcase
  end

  // Next-state for all registers; PCLoad takes priority over PCInc.
  always_comb begin
    ar_d = ar_q;
    dr_d = dr_q;
    ac_d = ac_q;
    ir_d = ir_q;
    pc_d = pc_q;
    if (dp.ARLoad) ar_d = bus_w[ADDR_W-1:0];
    if (dp.DRLoad) dr_d = bus_w;
    if (dp.IRLoad) ir_d = bus_w[DATA_W-1:DATA_W-3];
    if (dp.ACLoad) ac_d = alu_op(alu_sel_e'(dp.ALUSel) == ALU_SUB, ac_q, bus_w);
    if (dp.PCLoad)     pc_d = bus_w[ADDR_W-1:0];
    else if (dp.PCInc) pc_d = pc_q + 1'b1;
  end

  // Architectural registers, cleared immediately on reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ar_q <= '0;
      dr_q <= '0;
      pc_q <= '0;
      ac_q <= '0;
      ir_q <= '0;
    end else begin
      ar_q <= ar_d;
      dr_q <= dr_d;
      pc_q <= pc_d;
      ac_q <= ac_d;
      ir_q <= ir_d;
    end
  end

  // CPU stores are blocked during reset; program loads are not.
  assign ram_we_w = ~dp.memRW & ~RST;

  word_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i       (CLK),
    .we_i        (ram_we_w),
    .addr_i      (ar_q),
    .wdata_i     (bus_w),
    .prog_we_i   (dp.prog_we),
    .prog_addr_i (dp.prog_addr),
    .prog_data_i (dp.prog_data),
    .rdata_o     (mem_rdata_w)
  );

  assign dp.IR     = ir_q;
  assign dp.Z      = (ac_q == '0);
  assign dp.ac_out = ac_q;
  assign dp.pc_out = pc_q;

endmodule

// File: tb/tb_accumulator_datapath.sv
// Bench for accumulator_datapath: a directed vector table walking the
// reset/fetch/ALU/store/PC/write-conflict scenarios, then randomized strobes
// checked against a behavioural model of the register-transfer rules.
module tb_accumulator_datapath;
  import cpu_pkg::*;

  localparam int DW = 8;
  localparam int AW = 5;

  logic CLK = 1'b0;
  logic RST;

  accumulator_datapath_if #(.DATA_W(DW), .ADDR_W(AW)) dp_if ();

  accumulator_datapath #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK (CLK),
    .RST (RST),
    .dp  (dp_if)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] stb;   // {ARLoad,DRLoad,PCLoad,ACLoad,IRLoad,ALUSel,PCInc,memRW}
    logic [1:0] bsel;
    logic       pwe;
    logic [4:0] paddr;
    logic [7:0] pdata;
    logic [2:0] e_ir;
    logic       e_z;
    logic [7:0] e_ac;
    logic [4:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [7:0] stb, input logic [1:0] bsel,
                              input logic pwe, input logic [4:0] pa, input logic [7:0] pd,
                              input logic [2:0] ir, input logic z,
                              input logic [7:0] ac, input logic [4:0] pc);
    vec_t v;
    v.stb = stb; v.bsel = bsel; v.pwe = pwe; v.paddr = pa; v.pdata = pd;
    v.e_ir = ir; v.e_z = z; v.e_ac = ac; v.e_pc = pc;
    return v;
  endfunction

  task automatic drive(input logic [7:0] stb, input logic [1:0] bsel,
                       input logic pwe, input logic [4:0] pa, input logic [7:0] pd);
    dp_if.ARLoad    = stb[7];
    dp_if.DRLoad    = stb[6];
    dp_if.PCLoad    = stb[5];
    dp_if.ACLoad    = stb[4];
    dp_if.IRLoad    = stb[3];
    dp_if.ALUSel    = stb[2];
    dp_if.PCInc     = stb[1];
    dp_if.memRW     = stb[0];
    dp_if.BusSel    = bsel;
    dp_if.prog_we   = pwe;
    dp_if.prog_addr = pa;
    dp_if.prog_data = pd;
  endtask

  task automatic check(input string name, input logic [2:0] ir, input logic z,
                       input logic [7:0] ac, input logic [4:0] pc);
    checks++;
    if ({dp_if.IR, dp_if.Z, dp_if.ac_out, dp_if.pc_out} !== {ir, z, ac, pc}) begin
      errors++;
      $display("FAIL %s: got IR=%0d Z=%0b AC=%02h PC=%0d, want IR=%0d Z=%0b AC=%02h PC=%0d",
               name, dp_if.IR, dp_if.Z, dp_if.ac_out, dp_if.pc_out, ir, z, ac, pc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    drive(v.stb, v.bsel, v.pwe, v.paddr, v.pdata);
    tick();
    check($sformatf("vec%0d", idx), v.e_ir, v.e_z, v.e_ac, v.e_pc);
  endtask

  // Behavioural reference state for the random phase.
  int m_ar, m_dr, m_pc, m_ac, m_ir;
  int m_mem [32];

  task automatic model_step(input logic rst, input logic [7:0] stb, input logic [1:0] bsel,
                            input logic pwe, input int pa, input int pd);
    int bus, n_ac, n_pc;
    if (bsel == 2'd0)      bus = m_mem[m_ar];
    else if (bsel == 2'd1) bus = m_dr;
    else if (bsel == 2'd2) bus = m_pc;
    else                   bus = m_ac;
    if (pwe) m_mem[pa] = pd;
    else if (!rst && !stb[0]) m_mem[m_ar] = bus;
    if (rst) begin
      m_ar = 0; m_dr = 0; m_pc = 0; m_ac = 0; m_ir = 0;
    end else begin
      n_ac = stb[2] ? (m_ac - bus + 256) % 256 : (m_ac + bus) % 256;
      n_pc = stb[5] ? bus % 32 : (stb[1] ? (m_pc + 1) % 32 : m_pc);
      if (stb[4]) m_ac = n_ac;
      m_pc = n_pc;
      if (stb[7]) m_ar = bus % 32;
      if (stb[6]) m_dr = bus;
      if (stb[3]) m_ir = bus / 32;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Phase A: reach AC=0x37, PC=9 from M[0]=0x37, M[1]=0x09.
    vecs.push_back(mk(8'b0001_0001, 2'd0, 0, 0, 0,       3'd0, 1'b0, 8'h37, 5'd0));
    vecs.push_back(mk(8'b0000_0011, 2'd0, 0, 0, 0,       3'd0, 1'b0, 8'h37, 5'd1));
    vecs.push_back(mk(8'b1000_0001, 2'd2, 0, 0, 0,       3'd0, 1'b0, 8'h37, 5'd1));
    vecs.push_back(mk(8'b0010_0001, 2'd0, 0, 0, 0,       3'd0, 1'b0, 8'h37, 5'd9));
    // Fetch 1..3 of M[0]=0x45.
    vecs.push_back(mk(8'b1000_0001, 2'd2, 0, 0, 0,       3'd0, 1'b1, 8'h00, 5'd0));
    vecs.push_back(mk(8'b0100_0011, 2'd0, 0, 0, 0,       3'd0, 1'b1, 8'h00, 5'd1));
    vecs.push_back(mk(8'b1000_1001, 2'd1, 0, 0, 0,       3'd2, 1'b1, 8'h00, 5'd1));
    // Add wrap: AC=0xF0 + 0x20 -> 0x10.
    vecs.push_back(mk(8'b0000_0001, 2'd0, 1, 5, 8'hF0,   3'd2, 1'b1, 8'h00, 5'd1));
    vecs.push_back(mk(8'b0001_0001, 2'd0, 0, 0, 0,       3'd2, 1'b0, 8'hF0, 5'd1));
    vecs.push_back(mk(8'b0000_0001, 2'd0, 1, 5, 8'h20,   3'd2, 1'b0, 8'hF0, 5'd1));
    vecs.push_back(mk(8'b0100_0001, 2'd0, 0, 0, 0,       3'd2, 1'b0, 8'hF0, 5'd1));
    vecs.push_back(mk(8'b0001_0001, 2'd1, 0, 0, 0,       3'd2, 1'b0, 8'h10, 5'd1));
    // Subtract to zero: AC=0x01 - DR=0x01.
    vecs.push_back(mk(8'b0000_0001, 2'd0, 1, 5, 8'h0F,   3'd2, 1'b0, 8'h10, 5'd1));
    vecs.push_back(mk(8'b0001_0101, 2'd0, 0, 0, 0,       3'd2, 1'b0, 8'h01, 5'd1));
    vecs.push_back(mk(8'b0000_0001, 2'd0, 1, 5, 8'h01,   3'd2, 1'b0, 8'h01, 5'd1));
    vecs.push_back(mk(8'b0100_0001, 2'd0, 0, 0, 0,       3'd2, 1'b0, 8'h01, 5'd1));
    vecs.push_back(mk(8'b0001_0101, 2'd1, 0, 0, 0,       3'd2, 1'b1, 8'h00, 5'd1));
    // Store AC=0x5A to M[7], then read it back via AC - M[7].
    vecs.push_back(mk(8'b0000_0001, 2'd0, 1, 5, 8'h5A,   3'd2, 1'b1, 8'h00, 5'd1));
    vecs.push_back(mk(8'b0001_0001, 2'd0, 0, 0, 0,       3'd2, 1'b0, 8'h5A, 5'd1));
    vecs.push_back(mk(8'b0000_0001, 2'd0, 1, 5, 8'h07,   3'd2, 1'b0, 8'h5A, 5'd1));
    vecs.push_back(mk(8'b1000_0001, 2'd0, 0, 0, 0,       3'd2, 1'b0, 8'h5A, 5'd1));
    vecs.push_back(mk(8'b0100_0001, 2'd3, 0, 0, 0,       3'd2, 1'b0, 8'h5A, 5'd1));
    vecs.push_back(mk(8'b0000_0000, 2'd1, 0, 0, 0,       3'd2, 1'b0, 8'h5A, 5'd1));
    vecs.push_back(mk(8'b0001_0101, 2'd0, 0, 0, 0,       3'd2, 1'b1, 8'h00, 5'd1));
    // PC wrap 31 -> 0, then PCLoad beats PCInc.
    vecs.push_back(mk(8'b0000_0001, 2'd0, 1, 7, 8'h1F,   3'd2, 1'b1, 8'h00, 5'd1));
    vecs.push_back(mk(8'b0010_0001, 2'd0, 0, 0, 0,       3'd2, 1'b1, 8'h00, 5'd31));
    vecs.push_back(mk(8'b0000_0011, 2'd0, 0, 0, 0,       3'd2, 1'b1, 8'h00, 5'd0));
    vecs.push_back(mk(8'b0000_0001, 2'd0, 1, 7, 8'h0C,   3'd2, 1'b1, 8'h00, 5'd0));
    vecs.push_back(mk(8'b0100_0001, 2'd0, 0, 0, 0,       3'd2, 1'b1, 8'h00, 5'd0));
    vecs.push_back(mk(8'b0010_0011, 2'd1, 0, 0, 0,       3'd2, 1'b1, 8'h00, 5'd12));
    // Write conflict at M[3]: prog 0xAA beats CPU 0x55; 0x55-0xAA = 0xAB.
    vecs.push_back(mk(8'b0000_0001, 2'd0, 1, 7, 8'h03,   3'd2, 1'b1, 8'h00, 5'd12));
    vecs.push_back(mk(8'b1000_0001, 2'd0, 0, 0, 0,       3'd2, 1'b1, 8'h00, 5'd12));
    vecs.push_back(mk(8'b0000_0001, 2'd0, 1, 3, 8'h55,   3'd2, 1'b1, 8'h00, 5'd12));
    vecs.push_back(mk(8'b0001_0001, 2'd0, 0, 0, 0,       3'd2, 1'b0, 8'h55, 5'd12));
    vecs.push_back(mk(8'b0000_0000, 2'd3, 1, 3, 8'hAA,   3'd2, 1'b0, 8'h55, 5'd12));
    vecs.push_back(mk(8'b0001_0101, 2'd0, 0, 0, 0,       3'd2, 1'b0, 8'hAB, 5'd12));

    // Load the phase-A program under reset.
    RST = 1'b1;
    drive(8'b0000_0001, 2'd0, 1, 0, 8'h37);
    tick();
    drive(8'b0000_0001, 2'd0, 1, 1, 8'h09);
    tick();
    drive(8'b0000_0001, 2'd0, 0, 0, 0);
    check("reset_state", 3'd0, 1'b1, 8'h00, 5'd0);
    RST = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_vec(i);

    // Asynchronous reset in mid-cycle clears outputs before the next edge.
    #2 RST = 1'b1;
    #1 check("async_reset", 3'd0, 1'b1, 8'h00, 5'd0);
    drive(8'b0000_0001, 2'd0, 1, 0, 8'h45);
    tick();
    // CPU store to M[AR=0] must be ignored while reset is held.
    drive(8'b0000_0000, 2'd3, 1, 5, 8'h20);
    tick();
    drive(8'b0000_0001, 2'd0, 0, 0, 0);
    RST = 1'b0;
    tick();
    check("post_reset", 3'd0, 1'b1, 8'h00, 5'd0);

    for (int i = 4; i < vecs.size(); i++) run_vec(i);

    // Random phase: fill RAM under reset, then random strobes vs the model.
    RST = 1'b1;
    m_ar = 0; m_dr = 0; m_pc = 0; m_ac = 0; m_ir = 0;
    for (int a = 0; a < 32; a++) begin
      int d;
      d = int'($urandom_range(0, 255));
      drive(8'b0000_0001, 2'd0, 1, a[4:0], d[7:0]);
      tick();
      m_mem[a] = d;
    end
    drive(8'b0000_0001, 2'd0, 0, 0, 0);
    RST = 1'b0;
    tick();
    for (int n = 0; n < 400; n++) begin
      logic [7:0] stb;
      logic [1:0] bs;
      logic       pwe, rst;
      int         pa, pd;
      stb = 8'($urandom);
      bs  = 2'($urandom);
      pwe = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 31) == 0);
      pa  = int'($urandom_range(0, 31));
      pd  = int'($urandom_range(0, 255));
      RST = rst;
      drive(stb, bs, pwe, pa[4:0], pd[7:0]);
      @(posedge CLK);
      model_step(rst, stb, bs, pwe, pa, pd);
      @(negedge CLK);
      check($sformatf("rand%0d", n), m_ir[2:0], (m_ac == 0), m_ac[7:0], m_pc[4:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
